// File: rtl/fetch_pkg.sv
// Shared fetch definitions: architectural widths, NOP filler and the
// bundle record carried through the fetch queue.
package fetch_pkg;
  localparam int          XLEN      = 64;
  localparam int          INSTR_W   = 32;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam int          MAX_ISSUE = 4;

  // Lanes above the configured issue width carry NOP_INSTR.
  typedef struct packed {
    logic [XLEN-1:0]                  pc;
    logic [MAX_ISSUE-1:0][INSTR_W-1:0] instr;
    logic                             fault;
  } fetch_bundle_t;

  // Byte address of a lane; the PC is word-aligned before the lane offset is added.
  function automatic logic [XLEN-1:0] lane_addr(input logic [XLEN-1:0] pc, input int lane);
    return {pc[XLEN-1:2], 2'b00} + XLEN'(4 * lane);
  endfunction
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Dequeue side of the fetch unit: bundle head plus consumer ready.
interface instr_fetch_unit_if #(
  parameter int ISSUE_W = 2
);
  import fetch_pkg::*;

  logic                       deq_valid;
  logic                       deq_ready;
  logic [XLEN-1:0]            deq_pc;
  logic [ISSUE_W*INSTR_W-1:0] deq_instr;
  logic                       deq_fault;

  modport master (output deq_valid, output deq_pc, output deq_instr, output deq_fault,
                  input deq_ready);
  modport slave  (input deq_valid, input deq_pc, input deq_instr, input deq_fault,
                  output deq_ready);
endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush; head entry is readable combinationally.
module fetch_queue #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       enq_i,
  input  logic [W-1:0]               enq_data_i,
  input  logic                       deq_i,
  output logic [W-1:0]               head_data_o,
  output logic                       head_valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  store_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  // Pointer and occupancy tracking; flush and reset empty the queue at the edge.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (enq_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (deq_i) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(enq_i) - CW'(deq_i);
    end
  end

  // Entry storage; a write into the slot being dequeued sees the old value on the read side.
  always_ff @(posedge clk) begin
    if (enq_i && !rst && !flush_i) store_q[wr_ptr_q] <= enq_data_i;
  end

  assign head_data_o  = store_q[rd_ptr_q];
  assign head_valid_o = (count_q != '0);
  assign count_o      = count_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: program-loadable word store, fetch PC with redirect,
// bundle queue toward the decoder.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          ISSUE_W   = 2,
  parameter int          MEM_BYTES = 65536,
  parameter int          QDEPTH    = 4,
  parameter logic [63:0] RESET_PC  = 64'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 prog_we,
  input  logic [63:0]          prog_addr,
  input  logic [31:0]          prog_data,
  input  logic                 redirect_valid,
  input  logic [63:0]          redirect_pc,
  instr_fetch_unit_if.master   deq
);
  localparam int AW    = $clog2(MEM_BYTES);
  localparam int WORDS = MEM_BYTES / 4;
  localparam int CW    = $clog2(QDEPTH + 1);
  localparam int BW    = $bits(fetch_bundle_t);

  logic [31:0]     mem_q [WORDS];
  logic [XLEN-1:0] pc_q, pc_d;
  logic [AW-3:0]   lane_idx;
  fetch_bundle_t   enq_bundle, head_bundle;
  logic            head_valid, vis_valid, deq_fire, issue;
  logic [CW-1:0]   count;

  // Program load port; memory is never cleared by reset.
  always_ff @(posedge clk) begin
    if (prog_we) mem_q[(AW-2)'(prog_addr >> 2)] <= prog_data;
  end

  // Assemble the bundle for the current PC; lanes wrap modulo the store size.
  always_comb begin
    enq_bundle       = '0;
    lane_idx         = '0;
    enq_bundle.pc    = pc_q;
    enq_bundle.fault = |pc_q[1:0];
    for (int k = 0; k < MAX_ISSUE; k++) begin
      enq_bundle.instr[k] = NOP_INSTR;
      if (k < ISSUE_W) begin
        lane_idx            = (AW-2)'(lane_addr(pc_q, k) >> 2);
        enq_bundle.instr[k] = mem_q[lane_idx];
      end
    end
  end

  // Outputs are masked during reset so the head reads as empty immediately.
  assign vis_valid = head_valid && !rst;
  assign deq_fire  = vis_valid && deq.deq_ready;
  assign issue     = !rst && !redirect_valid && ((count != CW'(QDEPTH)) || deq_fire);

  // Next fetch PC: redirect wins over sequential advance.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid)  pc_d = redirect_pc;
    else if (issue)      pc_d = pc_q + XLEN'(4 * ISSUE_W);
  end

  // Fetch PC register.
  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  fetch_queue #(.W(BW), .DEPTH(QDEPTH)) u_queue (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (redirect_valid),
    .enq_i        (issue),
    .enq_data_i   (enq_bundle),
    .deq_i        (deq_fire),
    .head_data_o  (head_bundle),
    .head_valid_o (head_valid),
    .count_o      (count)
  );

  assign deq.deq_valid = vis_valid;
  assign deq.deq_pc    = vis_valid ? head_bundle.pc : '0;
  assign deq.deq_instr = vis_valid ? (ISSUE_W*INSTR_W)'(head_bundle.instr) : '0;
  assign deq.deq_fault = vis_valid & head_bundle.fault;
endmodule
